lcd_instruction_arbiter: RTL and testbench

Shares the single LCD controller between several instruction sources (e.g. a message sequencer and a status/debug writer). Each source requests the LCD for an atomic burst of 9-bit instructions. The arbiter grants round-robin, forwards each instruction over the controller's start/done handshake, and acknowledges it back to the owner. It sits between the requesting FSMs and the LCD controller instance, and replaces the direct LCD_start/LCD_instruction drive in the top level.

---
 rtl/lcd_pkg.sv | 17 +
 rtl/round_robin_picker.sv | 34 +++
 rtl/lcd_instruction_arbiter.sv | 143 ++++++++++++++
 tb/tb_lcd_instruction_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD instruction path.
package lcd_pkg;

  localparam int LCD_INSTR_W = 9;

  localparam logic [LCD_INSTR_W-1:0] LCD_CMD_HOME  = 9'h080;
  localparam logic [LCD_INSTR_W-1:0] LCD_CMD_LINE2 = 9'h0C0;
  localparam logic [LCD_INSTR_W-1:0] LCD_CMD_CLEAR = 9'h001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_INSTR,
    S_ISSUE,
    S_WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin choice: first set request searching upward from last_grant+1, with wrap.
module round_robin_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    // Walk from the farthest candidate back to the nearest, so the nearest set bit is kept.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant                   = '0;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        grant_idx               = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/lcd_instruction_arbiter.sv
// Round-robin owner of the LCD controller: forwards one atomic instruction burst at a time
// over the start/done handshake and acks each completed instruction back to its owner.
module lcd_instruction_arbiter
  import lcd_pkg::*;
#(
  parameter int          NUM_REQ      = 2,
  parameter logic [17:0] DONE_TIMEOUT = 18'h3FFFF
) (
  input  logic                         Clock_50,
  input  logic                         Reset,
  input  logic [NUM_REQ-1:0]           Req,
  output logic [NUM_REQ-1:0]           Grant,
  input  logic [NUM_REQ-1:0]           Instr_valid,
  input  logic [LCD_INSTR_W*NUM_REQ-1:0] Instr,
  input  logic [NUM_REQ-1:0]           Instr_last,
  output logic [NUM_REQ-1:0]           Instr_ack,
  output logic                         LCD_start,
  output logic [LCD_INSTR_W-1:0]       LCD_instruction,
  input  logic                         LCD_done,
  output logic                         Timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t             state_reg, state_next;
  logic [IDX_W-1:0]       owner_reg, owner_next;
  logic [IDX_W-1:0]       last_grant_reg, last_grant_next;
  logic                   last_flag_reg, last_flag_next;
  logic [17:0]            count_reg, count_next;
  logic [NUM_REQ-1:0]     grant_next, ack_next;
  logic                   start_next, terr_next;
  logic [LCD_INSTR_W-1:0] instr_next;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic [LCD_INSTR_W-1:0] instr_slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign instr_slice[gi] = Instr[LCD_INSTR_W*gi +: LCD_INSTR_W];
    end
  endgenerate

  round_robin_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (Req),
    .last_grant (last_grant_reg),
    .grant      (pick_grant),
    .grant_idx  (pick_idx)
  );

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    last_flag_next  = last_flag_reg;
    count_next      = count_reg;
    grant_next      = Grant;
    ack_next        = '0;
    start_next      = 1'b0;
    instr_next      = LCD_instruction;
    terr_next       = Timeout_err;

    case (state_reg)
      S_IDLE: begin
        if (|pick_grant) begin
          grant_next = pick_grant;
          owner_next = pick_idx;
          state_next = S_WAIT_INSTR;
        end
      end
      S_WAIT_INSTR: begin
        // A dropped request before the next instruction ends the burst early.
        if (!Req[owner_reg]) begin
          grant_next      = '0;
          last_grant_next = owner_reg;
          state_next      = S_IDLE;
        end else if (Instr_valid[owner_reg]) begin
          instr_next     = instr_slice[owner_reg];
          last_flag_next = Instr_last[owner_reg];
          start_next     = 1'b1;
          state_next     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        count_next = '0;
        state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (LCD_done) begin
          ack_next[owner_reg] = 1'b1;
          if (last_flag_reg) begin
            grant_next      = '0;
            last_grant_next = owner_reg;
            state_next      = S_IDLE;
          end else begin
            state_next = S_WAIT_INSTR;
          end
        end else if (count_reg == DONE_TIMEOUT) begin
          terr_next       = 1'b1;
          grant_next      = '0;
          last_grant_next = owner_reg;
          state_next      = S_IDLE;
        end else begin
          count_next = count_reg + 18'd1;
        end
      end
      default: begin
        grant_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_reg       <= S_IDLE;
      owner_reg       <= '0;
      last_grant_reg  <= IDX_W'(NUM_REQ - 1);
      last_flag_reg   <= 1'b0;
      count_reg       <= '0;
      Grant           <= '0;
      Instr_ack       <= '0;
      LCD_start       <= 1'b0;
      LCD_instruction <= '0;
      Timeout_err     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_grant_reg  <= last_grant_next;
      last_flag_reg   <= last_flag_next;
      count_reg       <= count_next;
      Grant           <= grant_next;
      Instr_ack       <= ack_next;
      LCD_start       <= start_next;
      LCD_instruction <= instr_next;
      Timeout_err     <= terr_next;
    end
  end

endmodule

// File: tb/tb_lcd_instruction_arbiter.sv
// Bench for lcd_instruction_arbiter: requester agents, a controller model, and a
// transaction-level reference model compared against the DUT every cycle.
module tb_lcd_instruction_arbiter;

  localparam int N   = 2;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, grant, valid, ilast, ack;
  logic [9*N-1:0] instr;
  logic           start, done, terr;
  logic [8:0]     lcd_instr;

  lcd_instruction_arbiter #(
    .NUM_REQ      (N),
    .DONE_TIMEOUT (18'd16)
  ) dut (
    .Clock_50        (clk),
    .Reset           (rst),
    .Req             (req),
    .Grant           (grant),
    .Instr_valid     (valid),
    .Instr           (instr),
    .Instr_last      (ilast),
    .Instr_ack       (ack),
    .LCD_start       (start),
    .LCD_instruction (lcd_instr),
    .LCD_done        (done),
    .Timeout_err     (terr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // requester agents and controller model
  bit         act[N], pend[N], abort_arm[N];
  int         blen[N], bidx[N], gap[N];
  logic [8:0] bdata[N][8];
  int         lat, ctl_cnt;
  bit         btb;

  // reference model: owner, outstanding instruction and its age in edges since issue
  int         m_owner, m_age, m_last_grant;
  bit         m_inflight, m_last_flag, m_terr;
  logic [8:0] m_instr;
  logic       exp_start;
  logic [N-1:0] exp_ack, exp_grant;

  // event logs
  logic [8:0]   start_log[$];
  int           start_cyc[$], start_own[$], ack_cyc[$], grant_log[$], grant_cyc[$];
  int           ack_cnt[N];
  int           grant_cycles, terr_cyc, cycle;
  logic [N-1:0] prev_grant, last_ack_grant;
  logic         prev_terr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, got, want);
    end
  endtask

  function automatic int owner_of(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic int int_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  function automatic logic [8:0] i9_at(input logic [8:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 'x;
  endfunction

  task automatic model_step();
    exp_start = 1'b0;
    exp_ack   = '0;
    if (rst) begin
      m_owner = -1; m_inflight = 0; m_age = 0; m_last_grant = N - 1;
      m_instr = '0; m_terr = 0; m_last_flag = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last_grant + k) % N;
        if (req[j]) begin
          m_owner = j;
          break;
        end
      end
    end else if (!m_inflight) begin
      if (!req[m_owner]) begin
        m_last_grant = m_owner;
        m_owner = -1;
      end else if (valid[m_owner]) begin
        m_instr = instr[9*m_owner +: 9];
        m_last_flag = ilast[m_owner];
        m_inflight = 1; m_age = 0; exp_start = 1'b1;
      end
    end else begin
      // done is only looked at from the second edge after issue onward
      m_age++;
      if (m_age >= 2 && done) begin
        exp_ack[m_owner] = 1'b1;
        m_inflight = 0;
        if (m_last_flag) begin
          m_last_grant = m_owner;
          m_owner = -1;
        end
      end else if (m_age == 2 + TMO) begin
        m_terr = 1; m_inflight = 0;
        m_last_grant = m_owner;
        m_owner = -1;
      end
    end
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
  endtask

  task automatic log_events();
    if (start) begin
      start_log.push_back(lcd_instr);
      start_cyc.push_back(cycle);
      start_own.push_back(owner_of(grant));
      $display("[%0d] start owner=%0d instr=%03h", cycle, owner_of(grant), lcd_instr);
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        ack_cnt[i]++;
        ack_cyc.push_back(cycle);
        last_ack_grant = grant;
      end
    end
    if (grant != '0 && prev_grant == '0) begin
      grant_log.push_back(owner_of(grant));
      grant_cyc.push_back(cycle);
    end
    if (grant != '0) grant_cycles++;
    if (terr && !prev_terr) begin
      terr_cyc = cycle;
      $display("[%0d] timeout flagged", cycle);
    end
    prev_grant = grant;
    prev_terr  = terr;
  endtask

  task automatic present(input int i);
    valid[i] = 1'b1;
    instr[9*i +: 9] = bdata[i][bidx[i]];
    ilast[i] = (bidx[i] == blen[i] - 1);
  endtask

  task automatic drive();
    done = 1'b0;
    if (start) ctl_cnt = lat;
    else if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) done = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (act[i]) begin
        if (ack[i]) begin
          bidx[i]++;
          if (bidx[i] == blen[i]) begin
            act[i] = 0; req[i] = 1'b0; valid[i] = 1'b0; ilast[i] = 1'b0;
          end else if (btb) begin
            present(i);
          end else begin
            valid[i] = 1'b0;
            gap[i] = $urandom_range(0, 2);
          end
        end else if (grant[i] && !valid[i]) begin
          if (abort_arm[i] && bidx[i] == 0) begin
            req[i] = 1'b0; act[i] = 0; abort_arm[i] = 0;
            $display("[%0d] requester %0d withdraws", cycle, i);
          end else if (gap[i] > 0) begin
            gap[i]--;
          end else begin
            present(i);
          end
        end
      end else if (pend[i]) begin
        pend[i] = 0; act[i] = 1; bidx[i] = 0;
        req[i] = 1'b1; valid[i] = 1'b0;
        gap[i] = $urandom_range(0, 2);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    model_step();
    chk("grant", grant, exp_grant);
    chk("instr_ack", ack, exp_ack);
    chk("lcd_start", start, exp_start);
    chk("lcd_instruction", lcd_instr, m_instr);
    chk("timeout_err", terr, m_terr);
    log_events();
    @(negedge clk);
    drive();
  endtask

  task automatic clear_logs();
    start_log.delete(); start_cyc.delete(); start_own.delete();
    ack_cyc.delete(); grant_log.delete(); grant_cyc.delete();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    grant_cycles = 0; terr_cyc = -1; last_ack_grant = 'x;
  endtask

  task automatic load_burst(input int i, input int n);
    blen[i] = n;
    abort_arm[i] = 0;
    for (int j = 0; j < 8; j++) bdata[i][j] = 9'($urandom_range(0, 511));
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) begin
      act[i] = 0; pend[i] = 0; abort_arm[i] = 0;
    end
    req = '0; valid = '0; ilast = '0; instr = '0; done = 1'b0; ctl_cnt = 0;
    rst = 1'b1;
    tick();
    chk("reset_grant", grant, 0);
    chk("reset_ack", ack, 0);
    chk("reset_start", start, 0);
    chk("reset_instr", lcd_instr, 0);
    chk("reset_terr", terr, 0);
    tick();
    rst = 1'b0;
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (act[i] || pend[i]) return 1;
    return 0;
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    for (int t = 0; t < budget && busy(); t++) tick();
    chk(name, busy(), 0);
  endtask

  initial begin
    int rounds[N];
    cycle = 0; lat = 5; btb = 0; prev_grant = '0; prev_terr = 1'b0;
    clear_logs();
    reset_dut();

    // single burst of three instructions, done 5 cycles after each start
    clear_logs();
    lat = 5; btb = 0;
    load_burst(0, 3);
    bdata[0][0] = 9'h080; bdata[0][1] = 9'h157; bdata[0][2] = 9'h165;
    pend[0] = 1;
    run_until_idle("single_complete", 200);
    chk("single_starts", start_log.size(), 3);
    chk("single_instr0", i9_at(start_log, 0), 9'h080);
    chk("single_instr1", i9_at(start_log, 1), 9'h157);
    chk("single_instr2", i9_at(start_log, 2), 9'h165);
    chk("single_acks", ack_cnt[0], 3);
    chk("single_grant_at_last_ack", last_ack_grant, 0);

    // contention: both request from reset and re-request once more
    reset_dut();
    clear_logs();
    lat = 2;
    for (int i = 0; i < N; i++) rounds[i] = 0;
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!act[i] && !pend[i] && rounds[i] < 2) begin
          load_burst(i, 3); pend[i] = 1; rounds[i]++;
        end
      end
      if (rounds[0] == 2 && rounds[1] == 2 && !busy()) break;
      tick();
    end
    chk("contend_complete", busy(), 0);
    chk("contend_grant0", int_at(grant_log, 0), 0);
    chk("contend_grant1", int_at(grant_log, 1), 1);
    chk("contend_grant2", int_at(grant_log, 2), 0);
    chk("contend_grant3", int_at(grant_log, 3), 1);
    chk("contend_own_mid", int_at(start_own, 1), 0);
    chk("contend_own_last0", int_at(start_own, 2), 0);
    chk("contend_own_first1", int_at(start_own, 3), 1);

    // abort: requester 1 drops Req right after being granted
    reset_dut();
    clear_logs();
    load_burst(1, 2); abort_arm[1] = 1; pend[1] = 1;
    run_until_idle("abort_complete", 50);
    tick(); tick();
    chk("abort_granted1", int_at(grant_log, 0), 1);
    chk("abort_no_start", start_log.size(), 0);
    chk("abort_grant_cycles", grant_cycles, 1);
    clear_logs();
    load_burst(0, 1); load_burst(1, 1); pend[0] = 1; pend[1] = 1;
    run_until_idle("abort_contend_complete", 100);
    chk("abort_then_grant0", int_at(grant_log, 0), 0);

    // timeout: controller never answers, requester 1 waits behind
    reset_dut();
    clear_logs();
    lat = -1;
    load_burst(0, 1); bdata[0][0] = 9'h001; pend[0] = 1;
    for (int t = 0; t < 50 && start_log.size() == 0; t++) tick();
    chk("tmo_started", start_log.size(), 1);
    load_burst(1, 2); pend[1] = 1;
    for (int t = 0; t < 60 && !terr; t++) tick();
    chk("tmo_flag", terr, 1);
    chk("tmo_latency", terr_cyc - int_at(start_cyc, 0), 2 + TMO);
    chk("tmo_no_ack", ack_cnt[0] + ack_cnt[1], 0);
    chk("tmo_release", grant, 0);
    tick();
    chk("tmo_next_grant", grant, 2'b10);
    lat = 3;
    run_until_idle("tmo_drain", 300);
    chk("tmo_sticky", terr, 1);

    // reset while waiting for done, then requester 0 must win first
    reset_dut();
    clear_logs();
    lat = 8;
    load_burst(0, 2); pend[0] = 1;
    for (int t = 0; t < 50 && start_log.size() == 0; t++) tick();
    chk("midreset_started", start_log.size(), 1);
    tick(); tick(); tick();
    reset_dut();
    clear_logs();
    lat = 3;
    load_burst(0, 1); load_burst(1, 1); pend[0] = 1; pend[1] = 1;
    run_until_idle("midreset_contend_complete", 100);
    chk("midreset_grant0", int_at(grant_log, 0), 0);

    // back-to-back: Instr_valid held through each ack; the held valid is sampled on the
    // edge that ends the ack cycle, so the next start is the cycle right after the ack
    clear_logs();
    lat = 4; btb = 1;
    load_burst(0, 3); pend[0] = 1;
    run_until_idle("b2b_complete", 200);
    chk("b2b_starts", start_log.size(), 3);
    chk("b2b_acks", ack_cnt[0], 3);
    chk("b2b_gap1", int_at(start_cyc, 1) - int_at(ack_cyc, 0), 1);
    chk("b2b_gap2", int_at(start_cyc, 2) - int_at(ack_cyc, 1), 1);

    // randomized traffic against the model
    reset_dut();
    clear_logs();
    for (int t = 0; t < 2000; t++) begin
      if ($urandom_range(0, 15) == 0)
        lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 10));
      btb = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if (!act[i] && !pend[i] && $urandom_range(0, 3) == 0) begin
          load_burst(i, int'($urandom_range(1, 5)));
          abort_arm[i] = ($urandom_range(0, 7) == 0);
          pend[i] = 1;
        end
      end
      if ($urandom_range(0, 599) == 0) reset_dut();
      else tick();
    end
    lat = 3;
    run_until_idle("random_drain", 1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
